// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response, decode-side
// stall/redirect controls, and the held-instruction outputs.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instrCode;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instrCode, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instrCode, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetcher: REQ -> WAIT -> HOLD, one instruction per 3 cycles best case.
// Holds the fetched word while stall is high; redirect overrides stall and grant, killing in-flight data.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        req_q;
  logic        valid_q;
  logic [31:0] code_q;
  logic [31:0] ipc_q;
  logic [31:0] target;

  assign target          = bus.redirect_pc & ALIGN_MASK;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instrCode   = code_q;
  assign bus.instr_pc    = ipc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= 32'h0;
      ipc_q   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.redirect) pc <= target;
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          // The address may only move while the request is still ungranted.
          if (bus.redirect) pc <= target;
          if (bus.imem_gnt) begin
            kill  <= bus.redirect;
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.redirect) pc <= target;
          if (bus.imem_rvalid) begin
            if (bus.redirect || kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              code_q  <= bus.imem_rdata;
              ipc_q   <= pc;
              state   <= S_HOLD;
              valid_q <= 1'b1;
            end
          end else if (bus.redirect) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.redirect || !bus.stall) begin
            pc      <= bus.redirect ? target : pc + 32'd4;
            valid_q <= 1'b0;
            state   <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer: a per-cycle stimulus/expectation table
// followed by hand-written stall, wrap and reset-in-flight sequences.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .ALIGN_MASK (32'hFFFF_FFFC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rvalid;
    logic [31:0] rdata;
    bit          stall;
    bit          redirect;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_code;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(bit r, bit g, bit rv, logic [31:0] rd, bit st, bit re,
                              logic [31:0] rp, bit eq, logic [31:0] ea, bit ev,
                              logic [31:0] ec, logic [31:0] ep);
    vec_t v;
    v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st;
    v.redirect = re; v.rpc = rp; v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
    v.e_code = ec; v.e_pc = ep;
    return v;
  endfunction

  task automatic step(bit r, bit g, bit rv, logic [31:0] rd, bit st, bit re, logic [31:0] rp);
    rst             = r;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.stall       = st;
    bus.redirect    = re;
    bus.redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, bit eq, logic [31:0] ea, bit ev,
                           logic [31:0] ec, logic [31:0] ep);
    cmp({tag, " imem_req"},    {31'h0, bus.imem_req},    {31'h0, eq});
    cmp({tag, " imem_addr"},   bus.imem_addr,            ea);
    cmp({tag, " instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, ev});
    cmp({tag, " instrCode"},   bus.instrCode,            ec);
    cmp({tag, " instr_pc"},    bus.instr_pc,             ep);
  endtask

  initial begin
    //            rst gnt rv rdata          st re rpc              req addr            vld code           pc
    vq.push_back(mk(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 32'h0000_0040,   0, 32'h0000_0000, 0, 32'h0,         32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_0000, 0, 32'h0,         32'h0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_0000, 0, 32'h0,         32'h0));
    vq.push_back(mk(0, 0, 1, 32'h11,        0, 0, 32'h0,           0, 32'h0000_0000, 1, 32'h11,        32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_0004, 0, 32'h11,        32'h0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_0004, 0, 32'h11,        32'h0));
    vq.push_back(mk(0, 0, 1, 32'h22,        0, 0, 32'h0,           0, 32'h0000_0004, 1, 32'h22,        32'h4));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_0008, 0, 32'h22,        32'h4));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_0008, 0, 32'h22,        32'h4));
    vq.push_back(mk(0, 0, 1, 32'h33,        0, 0, 32'h0,           0, 32'h0000_0008, 1, 32'h33,        32'h8));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_000C, 0, 32'h33,        32'h8));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_000C, 0, 32'h33,        32'h8));
    // redirect while waiting: the in-flight word must be dropped
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0100,   0, 32'h0000_0100, 0, 32'h33,        32'h8));
    vq.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,           1, 32'h0000_0100, 0, 32'h33,        32'h8));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_0100, 0, 32'h33,        32'h8));
    vq.push_back(mk(0, 0, 1, 32'h44,        0, 0, 32'h0,           0, 32'h0000_0100, 1, 32'h44,        32'h100));
    // redirect in HOLD with unaligned target
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0203,   1, 32'h0000_0200, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0300,   1, 32'h0000_0300, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 1, 32'h0000_0400,   0, 32'h0000_0400, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 0, 1, 32'h55,        0, 0, 32'h0,           1, 32'h0000_0400, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,           0, 32'h0000_0400, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 0, 1, 32'h66,        0, 1, 32'h0000_0500,   1, 32'h0000_0500, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 1, 1, 32'h77,        0, 0, 32'h0,           0, 32'h0000_0500, 0, 32'h44,        32'h100));
    vq.push_back(mk(0, 0, 1, 32'h88,        0, 0, 32'h0,           0, 32'h0000_0500, 1, 32'h88,        32'h500));
    vq.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,           0, 32'h0000_0500, 1, 32'h88,        32'h500));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_0504, 0, 32'h88,        32'h500));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,           1, 32'h0000_0504, 0, 32'h88,        32'h500));

    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].gnt, vq[i].rvalid, vq[i].rdata, vq[i].stall, vq[i].redirect, vq[i].rpc);
      check_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid, vq[i].e_code, vq[i].e_pc);
    end

    // Five stalled cycles in HOLD keep everything frozen.
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0050_0093, 0, 0, 32'h0);
    check_all("stall_enter", 0, 32'h504, 1, 32'h0050_0093, 32'h504);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 32'h0, 1, 0, 32'h0);
      check_all($sformatf("stall%0d", k), 0, 32'h504, 1, 32'h0050_0093, 32'h504);
    end
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_all("stall_release", 1, 32'h508, 0, 32'h0050_0093, 32'h504);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    check_all("wrap_redir", 1, 32'hFFFF_FFFC, 0, 32'h0050_0093, 32'h504);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 1, 32'hAAAA_5555, 0, 0, 32'h0);
    check_all("wrap_hold", 0, 32'hFFFF_FFFC, 1, 32'hAAAA_5555, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_all("wrap_next", 1, 32'h0000_0000, 0, 32'hAAAA_5555, 32'hFFFF_FFFC);

    // Reset during WAIT with a response landing in the reset cycle, then a late rvalid in IDLE.
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    step(1, 0, 1, 32'h0000_0BAD, 0, 0, 32'h0);
    check_all("rst_wait", 0, 32'h0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 32'h0000_0BAD, 0, 0, 32'h0);
    check_all("rst_late_rv", 1, 32'h0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h99, 0, 0, 32'h0);
    check_all("rst_first", 0, 32'h0, 1, 32'h99, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter ALIGN_MASK, default 32'hFFFF_FFFC, is applied to every loaded PC (forces word alignment).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals current PC.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle (valid only while imem_req=1).
REQ-008 imem_rvalid  input  1  read data valid; at most one outstanding request.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 stall  input  1  downstream (decode) cannot accept the held instruction.
REQ-011 redirect  input  1  branch/jump taken; load redirect_pc.
REQ-012 redirect_pc  input  32  new fetch target.
REQ-013 instr_valid  output  1  instrCode/instr_pc hold a valid instruction.
REQ-014 instrCode  output  32  registered instruction word.
REQ-015 instr_pc  output  32  address instrCode was fetched from.

Function
REQ-016 States: IDLE, REQ, WAIT, HOLD; encoding implementation-defined.
REQ-017 IDLE: imem_req=0, instr_valid=0; next cycle -> REQ unconditionally.
REQ-018 REQ: imem_req=1, imem_addr=PC; imem_gnt=1 -> WAIT; else stay REQ.
REQ-019 WAIT: imem_req=0; imem_rvalid=1 and kill=0 -> capture imem_rdata into instrCode, PC into instr_pc, -> HOLD.
REQ-020 WAIT: imem_rvalid=1 and kill=1 -> discard data, clear kill, -> REQ.
REQ-021 HOLD: instr_valid=1; stall=0 -> instruction consumed this cycle, PC <= PC+4, -> REQ (instr_valid=0 next cycle); stall=1 -> stay, outputs stable.
REQ-022 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect (any non-reset state, highest priority over stall/gnt): PC <= redirect_pc & ALIGN_MASK.
REQ-024 Redirect in IDLE: -> REQ; in REQ with imem_gnt=0: stay REQ, new address presented next cycle (address change permitted only while ungranted).
REQ-025 Redirect in REQ with imem_gnt=1, or in WAIT with imem_rvalid=0: set kill=1, -> WAIT.
REQ-026 Redirect in WAIT with imem_rvalid=1: data discarded, kill cleared, -> REQ.
REQ-027 Redirect in HOLD: instr_valid=0 next cycle, -> REQ; held instruction is dropped even if stall=0.
REQ-028 imem_rvalid outside WAIT ignored; imem_gnt outside REQ ignored.
REQ-029 imem_addr and imem_req stable while in REQ and no redirect.
REQ-030 Minimum fetch throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with single-cycle grant and response.

Reset
REQ-031 rst=1 at a rising edge forces: state=IDLE, PC=RESET_PC, kill=0, imem_req=0, instr_valid=0, instrCode=0, instr_pc=0.
REQ-032 Reset mid-transaction abandons any outstanding request; a late imem_rvalid after reset is ignored (arrives in IDLE/REQ).
REQ-033 rst dominates redirect, stall, gnt, rvalid in the same cycle.

Verification
REQ-034 Reset release, gnt and rvalid returned one cycle after each request, stall=0 -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses with instr_pc 0x0,0x4,0x8.
REQ-035 stall=1 for 5 cycles during HOLD with instrCode=0x00500093 -> instr_valid, instrCode, instr_pc unchanged for all 5 cycles; imem_req=0 throughout.
REQ-036 Redirect to 0x100 in WAIT, then rvalid with rdata=0xDEADBEEF -> 0xDEADBEEF never appears on instrCode; next imem_addr=0x100.
REQ-037 Redirect to 0x203 in HOLD with stall=0 -> instr_valid=0 next cycle, next imem_addr=0x200.
REQ-038 PC at 0xFFFF_FFFC, consumed -> next imem_addr=0x0000_0000.
REQ-039 rst asserted in WAIT, rvalid arrives during reset cycle -> all outputs at reset values; first post-reset imem_addr=RESET_PC.
